// File: rtl/m_dm_ctrl_pkg.sv
// Shared access-type codes, FSM state encoding and legality helper for the
// M-stage data-memory controller.
package m_dm_ctrl_pkg;

   localparam logic [1:0] TYPE_W = 2'b00;
   localparam logic [1:0] TYPE_H = 2'b01;
   localparam logic [1:0] TYPE_B = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_REQ    = 2'b01,
      S_WAIT_R = 2'b10,
      S_DONE   = 2'b11
   } state_t;

   // Natural alignment: words on 4-byte, halves on 2-byte boundaries; 2'b11 never legal.
   function automatic logic access_legal(input logic [1:0] acc_type,
                                         input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (acc_type)
         TYPE_W:  ok = (addr_lo == 2'b00);
         TYPE_H:  ok = (addr_lo[0] == 1'b0);
         TYPE_B:  ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/m_dm_be.sv
// Byte-lane generator: turns access size and low address bits into byte
// enables, lane-replicated store data and a legality flag.
module m_dm_be
   import m_dm_ctrl_pkg::*;
(
   input  logic [1:0]  acc_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_data,
   output logic        legal
);

   always_comb begin
      be        = 4'b0000;
      lane_data = wdata;
      legal     = access_legal(acc_type, addr_lo);
      case (acc_type)
         TYPE_W: be = 4'b1111;
         TYPE_H: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata[15:0]}};
         end
         TYPE_B: begin
            be        = 4'b0001 << addr_lo;
            lane_data = {4{wdata[7:0]}};
         end
         default: be = 4'b0000;
      endcase
   end

endmodule

// File: rtl/m_dm_ctrl.sv
// M-stage data-memory controller: req/gnt/rvalid bus handshake, pipeline
// stall generation and capture of the raw read word for the extension stage.
module m_dm_ctrl
   import m_dm_ctrl_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [1:0]    req_type,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          stall,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [3:0]    bus_be,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_gnt,
   input  logic          bus_rvalid,
   input  logic [DW-1:0] bus_rdata,
   output logic [DW-1:0] rdata,
   output logic          rdata_valid,
   output logic [1:0]    ext_type,
   output logic [1:0]    ext_addr,
   output logic          exc_adel,
   output logic          exc_ades
);

   state_t        state;
   state_t        next_state;

   logic          lat_we;
   logic [1:0]    lat_type;
   logic [AW-1:0] lat_addr;
   logic [3:0]    lat_be;
   logic [DW-1:0] lat_wdata;

   logic [3:0]    be_now;
   logic [DW-1:0] lane_now;
   logic          legal_now;
   logic          latch_en;
   logic          capture;

   m_dm_be u_be (
      .acc_type  (req_type),
      .addr_lo   (req_addr[1:0]),
      .wdata     (req_wdata),
      .be        (be_now),
      .lane_data (lane_now),
      .legal     (legal_now)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Legality and exceptions only matter in IDLE; later states belong to the in-flight op.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      bus_req    = 1'b0;
      latch_en   = 1'b0;
      capture    = 1'b0;
      exc_adel   = 1'b0;
      exc_ades   = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (legal_now) begin
                  stall      = 1'b1;
                  latch_en   = 1'b1;
                  next_state = S_REQ;
               end else begin
                  exc_adel = !req_we;
                  exc_ades = req_we;
               end
            end
         end
         S_REQ: begin
            bus_req = 1'b1;
            stall   = 1'b1;
            if (bus_gnt) begin
               if (lat_we) begin
                  next_state = S_DONE;
               end else if (bus_rvalid) begin
                  capture    = 1'b1;
                  next_state = S_DONE;
               end else begin
                  next_state = S_WAIT_R;
               end
            end
         end
         S_WAIT_R: begin
            stall = 1'b1;
            if (bus_rvalid) begin
               capture    = 1'b1;
               next_state = S_DONE;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_we    <= 1'b0;
         lat_type  <= TYPE_W;
         lat_addr  <= '0;
         lat_be    <= 4'b0000;
         lat_wdata <= '0;
      end else if (latch_en) begin
         lat_we    <= req_we;
         lat_type  <= req_type;
         lat_addr  <= req_addr;
         lat_be    <= be_now;
         lat_wdata <= lane_now;
      end
   end

   // Read results persist until the next completed load overwrites them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata    <= '0;
         ext_type <= TYPE_W;
         ext_addr <= 2'b00;
      end else if (capture) begin
         rdata    <= bus_rdata;
         ext_type <= lat_type;
         ext_addr <= lat_addr[1:0];
      end
   end

   assign bus_we      = lat_we;
   assign bus_addr    = {lat_addr[AW-1:2], 2'b00};
   assign bus_be      = lat_be;
   assign bus_wdata   = lat_wdata;
   assign rdata_valid = (state == S_DONE) && !lat_we;

endmodule

// File: tb/tb_m_dm_ctrl.sv
// Randomized self-checking bench for m_dm_ctrl; the bench plays the memory bus
// and predicts every output from an arithmetic model of the access rules.
module tb_m_dm_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic [1:0]  ext_type;
   logic [1:0]  ext_addr;
   logic        exc_adel;
   logic        exc_ades;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] m_rdata;
   logic [1:0]  m_ext_type;
   logic [1:0]  m_ext_addr;

   m_dm_ctrl #(.AW(32), .DW(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_type    (req_type),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .stall       (stall),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_gnt     (bus_gnt),
      .bus_rvalid  (bus_rvalid),
      .bus_rdata   (bus_rdata),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .ext_type    (ext_type),
      .ext_addr    (ext_addr),
      .exc_adel    (exc_adel),
      .exc_ades    (exc_ades)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int accBytes(input logic [1:0] t);
      case (t)
         2'b00:   return 4;
         2'b01:   return 2;
         2'b10:   return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic modelLegal(input logic [1:0] t, input logic [31:0] a);
      int n;
      n = accBytes(t);
      return (n != 0) && ((a % n) == 0);
   endfunction

   function automatic logic [3:0] modelBe(input logic [1:0] t, input logic [31:0] a);
      int n;
      int m;
      n = accBytes(t);
      m = ((1 << n) - 1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] modelLanes(input logic [1:0] t, input logic [31:0] wd);
      logic [31:0] r;
      int n;
      n = accBytes(t);
      r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   // One complete M-stage instruction: grant arrives g REQ cycles late, read data rd cycles after grant.
   task automatic applyStimulus(input logic we, input logic [1:0] t, input logic [31:0] addr,
                                input logic [31:0] wd, input int g, input int rd,
                                input logic [31:0] rdat);
      int done_idx;
      if (!modelLegal(t, addr)) begin
         @(negedge clk);
         req_valid = 1'b1; req_we = we; req_type = t; req_addr = addr; req_wdata = wd;
         bus_gnt = 1'($urandom % 2); bus_rvalid = 1'b0;
         #1;
         checkOutput("exc_adel", exc_adel, !we);
         checkOutput("exc_ades", exc_ades, we);
         checkOutput("illegal_stall", stall, 1'b0);
         checkOutput("illegal_bus_req", bus_req, 1'b0);
         @(negedge clk);
         req_valid = 1'b0; bus_gnt = 1'b0;
         #1;
         checkOutput("illegal_bus_req_after", bus_req, 1'b0);
         checkOutput("illegal_stall_after", stall, 1'b0);
         return;
      end
      done_idx = 2 + g + (we ? 0 : rd);
      for (int c = 0; c <= done_idx; c++) begin
         @(negedge clk);
         req_valid = 1'b1; req_we = we; req_type = t; req_addr = addr; req_wdata = wd;
         bus_gnt = (c == 1 + g) || ((c > 1 + g) && ($urandom % 2 == 1));
         if (!we && c == 1 + g + rd) begin
            bus_rvalid = 1'b1; bus_rdata = rdat;
         end else if (c == 0 || c >= done_idx) begin
            bus_rvalid = 1'($urandom % 2); bus_rdata = $urandom;
         end else begin
            bus_rvalid = 1'b0; bus_rdata = $urandom;
         end
         #1;
         checkOutput("stall", stall, c < done_idx);
         checkOutput("bus_req", bus_req, (c >= 1) && (c <= 1 + g));
         checkOutput("rdata_valid", rdata_valid, (c == done_idx) && !we);
         checkOutput("exc_any", {exc_adel, exc_ades}, 2'b00);
         if (c >= 1 && c <= 1 + g) begin
            checkOutput("bus_we", bus_we, we);
            checkOutput("bus_addr", bus_addr, {addr[31:2], 2'b00});
            checkOutput("bus_be", bus_be, modelBe(t, addr));
            if (we) checkOutput("bus_wdata", bus_wdata, modelLanes(t, wd));
         end
         if (c == done_idx) begin
            if (!we) begin
               m_rdata = rdat; m_ext_type = t; m_ext_addr = addr[1:0];
            end
            checkOutput("rdata", rdata, m_rdata);
            checkOutput("ext_type", ext_type, m_ext_type);
            checkOutput("ext_addr", ext_addr, m_ext_addr);
         end
      end
      @(negedge clk);
      req_valid = 1'b0; bus_gnt = 1'($urandom % 2); bus_rvalid = 1'($urandom % 2); bus_rdata = $urandom;
      #1;
      checkOutput("idle_rdata_valid", rdata_valid, 1'b0);
      checkOutput("idle_stall", stall, 1'b0);
      checkOutput("idle_bus_req", bus_req, 1'b0);
      checkOutput("idle_rdata_hold", rdata, m_rdata);
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = 2'b00;
      req_addr = '0; req_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      m_rdata = '0; m_ext_type = 2'b00; m_ext_addr = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_bus_req", bus_req, 1'b0);
      checkOutput("reset_stall", stall, 1'b0);
      checkOutput("reset_rdata", rdata, 32'h0);
      checkOutput("reset_rdata_valid", rdata_valid, 1'b0);
      checkOutput("reset_ext_type", ext_type, 2'b00);
      checkOutput("reset_ext_addr", ext_addr, 2'b00);
      reset_n = 1'b1;

      applyStimulus(1'b1, 2'b00, 32'h10, 32'h12345678, 1, 0, 32'h0);
      applyStimulus(1'b1, 2'b10, 32'h13, 32'h000000AB, 0, 0, 32'h0);
      applyStimulus(1'b0, 2'b01, 32'h22, 32'h0, 0, 3, 32'hBEEF1234);
      applyStimulus(1'b0, 2'b00, 32'h05, 32'h0, 0, 0, 32'h0);
      applyStimulus(1'b1, 2'b01, 32'h03, 32'h5555AAAA, 0, 0, 32'h0);
      applyStimulus(1'b0, 2'b11, 32'h40, 32'h0, 0, 0, 32'h0);
      applyStimulus(1'b0, 2'b10, 32'h47, 32'h0, 2, 0, 32'hCAFEF00D);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom % 2), 2'($urandom % 4), $urandom, $urandom,
                       int'($urandom % 4), int'($urandom % 4), $urandom);
      end

      // Abort a load parked in WAIT_R with an asynchronous reset.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_type = 2'b00; req_addr = 32'h40;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      checkOutput("abort_wait_stall", stall, 1'b1);
      checkOutput("abort_wait_bus_req", bus_req, 1'b0);
      req_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      m_rdata = '0; m_ext_type = 2'b00; m_ext_addr = 2'b00;
      checkOutput("abort_bus_req", bus_req, 1'b0);
      checkOutput("abort_stall", stall, 1'b0);
      checkOutput("abort_rdata", rdata, m_rdata);
      checkOutput("abort_ext_type", ext_type, m_ext_type);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
         #1;
         checkOutput("abort_late_rdata_valid", rdata_valid, 1'b0);
         checkOutput("abort_late_rdata", rdata, m_rdata);
         checkOutput("abort_late_bus_req", bus_req, 1'b0);
      end
      bus_rvalid = 1'b0;

      applyStimulus(1'b0, 2'b01, 32'h22, 32'h0, 1, 1, 32'h0BAD0F00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
